// File: rtl/mprj_io_serial_loader.sv
//==============================================================================
// Module   : mprj_io_serial_loader
// Purpose  : Moves the per-pad IO configuration words from the project-control
//            register file into the GPIO pad configuration shift chain. On a
//            start pulse it fetches each pad's word, starting at pad IO_PADS-1.
//            It shifts each word out MSB-first with a generated serial clock.
//            It then pulses serial_load to latch the chain into the pads.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters
//   IO_PADS   number of pads in the chain
//   CFG_BITS  configuration bits per pad
//   CLK_DIV   system cycles per serial_clock phase (1..255)
// Ports
//   wb_clk_i         in   system clock
//   resetn           in   asynchronous, active-low reset
//   xfer_start       in   one-cycle start request (ignored unless idle)
//   xfer_abort       in   abort request        (MPRJ_IO_LOADER_ABORT_EN only)
//   cfg_idx          out  index of the pad word being fetched
//   cfg_data         in   config word for cfg_idx, valid the same cycle
//   serial_clock     out  chain shift clock, data captured on its rising edge
//   serial_data_out  out  serial configuration data
//   serial_load      out  chain latch strobe
//   busy             out  transfer in progress
//   done             out  one-cycle completion pulse
//   aborted          out  last transfer was aborted (MPRJ_IO_LOADER_ABORT_EN)
// Optional feature macro: MPRJ_IO_LOADER_ABORT_EN
//==============================================================================
`default_nettype none

module mprj_io_serial_loader #(
  parameter int IO_PADS  = 38,
  parameter int CFG_BITS = 13,
  parameter int CLK_DIV  = 1,
  localparam int IDX_W   = (IO_PADS > 1) ? $clog2(IO_PADS) : 1
) (
  input  logic                wb_clk_i,
  input  logic                resetn,
  input  logic                xfer_start,
`ifdef MPRJ_IO_LOADER_ABORT_EN
  input  logic                xfer_abort,
  output logic                aborted,
`endif
  output logic [IDX_W-1:0]    cfg_idx,
  input  logic [CFG_BITS-1:0] cfg_data,
  output logic                serial_clock,
  output logic                serial_data_out,
  output logic                serial_load,
  output logic                busy,
  output logic                done
);

  localparam int BIT_W = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

  localparam logic [7:0]       PHASE_LAST = 8'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_TOP    = BIT_W'(CFG_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_TOP    = IDX_W'(IO_PADS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SH_LO = 3'd2,
    SH_HI = 3'd3,
    LOAD  = 3'd4,
    FIN   = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           phase_q, phase_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CFG_BITS-1:0]  shreg_q, shreg_d;
  logic                 serial_clock_q, serial_clock_d;
  logic                 serial_data_q, serial_data_d;
  logic                 serial_load_q, serial_load_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 phase_last;
`ifdef MPRJ_IO_LOADER_ABORT_EN
  logic                 aborted_q, aborted_d;
  logic                 abort_take;
`endif

  assign phase_last = (phase_q == PHASE_LAST);

`ifdef MPRJ_IO_LOADER_ABORT_EN
  // Abort is only meaningful while the chain is being driven; IDLE has nothing
  // to stop and FIN is already the exit path.
  assign abort_take = xfer_abort && (state_q != IDLE) && (state_q != FIN);
`endif

  //--------------------------------------------------------------------------
  // State register and datapath flops
  //--------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      phase_q        <= 8'd0;
      bit_cnt_q      <= '0;
      idx_q          <= '0;
      shreg_q        <= '0;
      serial_clock_q <= 1'b0;
      serial_data_q  <= 1'b0;
      serial_load_q  <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
`ifdef MPRJ_IO_LOADER_ABORT_EN
      aborted_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      bit_cnt_q      <= bit_cnt_d;
      idx_q          <= idx_d;
      shreg_q        <= shreg_d;
      serial_clock_q <= serial_clock_d;
      serial_data_q  <= serial_data_d;
      serial_load_q  <= serial_load_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
`ifdef MPRJ_IO_LOADER_ABORT_EN
      aborted_q      <= aborted_d;
`endif
    end
  end

  //--------------------------------------------------------------------------
  // Next-state and datapath logic
  //--------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    // The phase counter restarts from zero on every state entry; it only
    // advances while a timed state is still short of its last cycle.
    phase_d   = 8'd0;
    bit_cnt_d = bit_cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
`ifdef MPRJ_IO_LOADER_ABORT_EN
    aborted_d = aborted_q;
`endif

    case (state_q)
      IDLE: begin
        if (xfer_start) begin
          state_d = FETCH;
          idx_d   = IDX_TOP;
`ifdef MPRJ_IO_LOADER_ABORT_EN
          aborted_d = 1'b0;
`endif
        end
      end

      FETCH: begin
        shreg_d   = cfg_data;
        bit_cnt_d = BIT_TOP;
        state_d   = SH_LO;
      end

      SH_LO: begin
        if (phase_last) begin
          state_d = SH_HI;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end

      SH_HI: begin
        if (phase_last) begin
          shreg_d = shreg_q << 1;
          if (bit_cnt_q == '0) begin
            if (idx_q == '0) begin
              state_d = LOAD;
            end else begin
              idx_d   = idx_q - IDX_W'(1);
              state_d = FETCH;
            end
          end else begin
            bit_cnt_d = bit_cnt_q - BIT_W'(1);
            state_d   = SH_LO;
          end
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end

      LOAD: begin
        if (phase_last) begin
          state_d = FIN;
        end else begin
          phase_d = phase_q + 8'd1;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef MPRJ_IO_LOADER_ABORT_EN
    // Abort wins over whatever transition the case above picked.
    if (abort_take) begin
      state_d   = FIN;
      phase_d   = 8'd0;
      aborted_d = 1'b1;
    end
`endif
  end

  //--------------------------------------------------------------------------
  // Output decode from the next state so every output is a flop aligned with
  // the state it describes. serial_data follows the shift register MSB only
  // while shifting, so it stays constant across a low/high pair and returns
  // to zero everywhere else.
  //--------------------------------------------------------------------------
  always_comb begin
    serial_clock_d = (state_d == SH_HI);
    serial_load_d  = (state_d == LOAD);
    done_d         = (state_d == FIN);
    busy_d         = (state_d == FETCH) || (state_d == SH_LO) ||
                     (state_d == SH_HI) || (state_d == LOAD);
    serial_data_d  = 1'b0;
    if ((state_d == SH_LO) || (state_d == SH_HI)) begin
      serial_data_d = shreg_d[CFG_BITS-1];
    end
  end

  assign cfg_idx         = idx_q;
  assign serial_clock    = serial_clock_q;
  assign serial_data_out = serial_data_q;
  assign serial_load     = serial_load_q;
  assign busy            = busy_q;
  assign done            = done_q;
`ifdef MPRJ_IO_LOADER_ABORT_EN
  assign aborted         = aborted_q;
`endif

endmodule

`default_nettype wire
